// File: rtl/bc_accum_pkg.sv
// Shared types and helpers for the box-count stages.
package bc_accum_pkg;

    localparam int unsigned BC_BOX_IDX  = 3;
    localparam int unsigned BC_PIX_BITS = 8;
    localparam int unsigned BC_DATA_LEN = 8;
    localparam int unsigned BC_AW       = 2 * BC_BOX_IDX + 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        DONE
    } bc_state_e;

    typedef logic [BC_AW-1:0] addr_t;

    // Bank 0 holds the finest level; bank 1 belongs to the grouping stage.
    localparam logic BANK_FINE   = 1'b0;
    localparam logic BANK_COARSE = 1'b1;

    // Memory address layout shared by every stage: {x, bank, y}.
    function automatic addr_t pack_addr(input logic [BC_BOX_IDX-1:0] x,
                                        input logic                  bank,
                                        input logic [BC_BOX_IDX-1:0] y);
        return {x, bank, y};
    endfunction

endpackage

// File: rtl/bc_accum_if.sv
// Pixel stream handshake between the pixel source and the box-count stage.
interface bc_accum_if #(
    parameter int unsigned PIX_BITS = 8
);
    logic                pix_valid;
    logic                pix_ready;
    logic [PIX_BITS-1:0] pix_x;
    logic [PIX_BITS-1:0] pix_y;
    logic                pix_hit;
    logic                pix_last;

    modport master (
        output pix_valid, pix_x, pix_y, pix_hit, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_hit, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/bc_rmw_pipe.sv
// Read-modify-write stage: S1 register, same-address forwarding and saturating increment.
module bc_rmw_pipe #(
    parameter int unsigned AW       = 7,
    parameter int unsigned DATA_LEN = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                load,
    input  logic [AW-1:0]       load_addr,
    input  logic [DATA_LEN-1:0] rdata,
    output logic                wen,
    output logic [AW-1:0]       wr_addr,
    output logic [DATA_LEN-1:0] wdata
);

    logic                s1_valid_q;
    logic [AW-1:0]       s1_addr_q;
    logic                prev_wen_q;
    logic [AW-1:0]       prev_addr_q;
    logic [DATA_LEN-1:0] prev_wdata_q;
    logic [DATA_LEN-1:0] src;
    logic [DATA_LEN-1:0] inc;

    // Pipeline registers: S1 slot plus a copy of last cycle's write for forwarding.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            prev_wen_q   <= 1'b0;
            prev_addr_q  <= '0;
            prev_wdata_q <= '0;
        end else begin
            s1_valid_q   <= load;
            if (load) begin
                s1_addr_q <= load_addr;
            end
            prev_wen_q   <= s1_valid_q;
            prev_addr_q  <= s1_addr_q;
            prev_wdata_q <= inc;
        end
    end

    // The RAM is read-first, so a write issued last cycle to this address is not yet in rdata.
    always_comb begin
        src = rdata;
        if (prev_wen_q && (prev_addr_q == s1_addr_q)) begin
            src = prev_wdata_q;
        end
        inc     = (&src) ? src : src + DATA_LEN'(1);
        wen     = s1_valid_q;
        wr_addr = s1_valid_q ? s1_addr_q : '0;
        wdata   = s1_valid_q ? inc : '0;
    end

endmodule

// File: rtl/bc_accum.sv
// Box-count accumulation: clears the finest bank, then counts hits per box from a pixel stream.
module bc_accum
    import bc_accum_pkg::*;
#(
    parameter int unsigned BOX_IDX  = BC_BOX_IDX,
    parameter int unsigned PIX_BITS = BC_PIX_BITS,
    parameter int unsigned DATA_LEN = BC_DATA_LEN
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    bc_accum_if.slave             pix,
    output logic                  BC_mode,
    output logic [2*BOX_IDX:0]    BC_rd_addr,
    input  logic [DATA_LEN-1:0]   BC_rdata,
    output logic [2*BOX_IDX:0]    BC_wr_addr,
    output logic [DATA_LEN-1:0]   BC_wdata,
    output logic                  wen_bc,
    output logic [2*PIX_BITS:0]   hit_count,
    output logic                  done
);

    localparam int unsigned AW  = 2 * BOX_IDX + 1;
    localparam int unsigned HCW = 2 * PIX_BITS + 1;

    bc_state_e             state_q, state_d;
    logic [2*BOX_IDX-1:0]  clr_q;
    logic [HCW-1:0]        hit_cnt_q;
    logic                  done_q;

    logic                  accept;
    logic                  accept_hit;
    logic                  start_ok;
    logic                  clr_last;
    logic [BOX_IDX-1:0]    box_x, box_y;
    logic [AW-1:0]         pix_addr;
    logic [AW-1:0]         clr_addr;

    logic                  pipe_wen;
    logic [AW-1:0]         pipe_addr;
    logic [DATA_LEN-1:0]   pipe_wdata;

    // Box index is the top BOX_IDX bits of each pixel coordinate.
    assign box_x      = pix.pix_x[PIX_BITS-1 -: BOX_IDX];
    assign box_y      = pix.pix_y[PIX_BITS-1 -: BOX_IDX];
    assign pix_addr   = pack_addr(box_x, BANK_FINE, box_y);
    assign clr_addr   = pack_addr(clr_q[2*BOX_IDX-1 -: BOX_IDX], BANK_FINE, clr_q[BOX_IDX-1:0]);

    assign accept     = (state_q == ACCUM) && pix.pix_valid;
    assign accept_hit = accept && pix.pix_hit;
    assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
    assign clr_last   = &clr_q;

    assign hit_count  = hit_cnt_q;
    assign done       = done_q;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   if (clr_last) state_d = ACCUM;
            ACCUM:   if (accept && pix.pix_last) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (start) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
    end

    // Clear sweep counter, hit counter and the one-shot done pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_q     <= '0;
            hit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                clr_q <= '0;
            end else if (state_q == CLEAR) begin
                clr_q <= clr_q + (2*BOX_IDX)'(1);
            end
            if (start_ok) begin
                hit_cnt_q <= '0;
            end else if (accept_hit && !(&hit_cnt_q)) begin
                hit_cnt_q <= hit_cnt_q + HCW'(1);
            end
            done_q <= (state_d == DONE) && (state_q != DONE);
        end
    end

    bc_rmw_pipe #(
        .AW       (AW),
        .DATA_LEN (DATA_LEN)
    ) u_rmw (
        .CLK       (CLK),
        .RST       (RST),
        .load      (accept_hit),
        .load_addr (pix_addr),
        .rdata     (BC_rdata),
        .wen       (pipe_wen),
        .wr_addr   (pipe_addr),
        .wdata     (pipe_wdata)
    );

    // Output decode: memory port ownership and handshake per state.
    always_comb begin
        pix.pix_ready = 1'b0;
        BC_mode       = 1'b1;
        BC_rd_addr    = '0;
        BC_wr_addr    = '0;
        BC_wdata      = '0;
        wen_bc        = 1'b0;
        unique case (state_q)
            CLEAR: begin
                wen_bc     = 1'b1;
                BC_wr_addr = clr_addr;
            end
            ACCUM: begin
                pix.pix_ready = 1'b1;
                if (accept_hit) begin
                    BC_rd_addr = pix_addr;
                end
                wen_bc     = pipe_wen;
                BC_wr_addr = pipe_addr;
                BC_wdata   = pipe_wdata;
            end
            DRAIN: begin
                wen_bc     = pipe_wen;
                BC_wr_addr = pipe_addr;
                BC_wdata   = pipe_wdata;
            end
            // Memory is released to the grouping stage unless a new frame starts now.
            DONE:    BC_mode = start;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bc_accum.sv
module tb_bc_accum;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic       BC_mode;
    logic [6:0] BC_rd_addr;
    logic [7:0] BC_rdata;
    logic [6:0] BC_wr_addr;
    logic [7:0] BC_wdata;
    logic       wen_bc;
    logic [16:0] hit_count;
    logic       done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] mem [0:127];

    bc_accum_if #(.PIX_BITS(8)) pix_if ();

    bc_accum dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .pix        (pix_if),
        .BC_mode    (BC_mode),
        .BC_rd_addr (BC_rd_addr),
        .BC_rdata   (BC_rdata),
        .BC_wr_addr (BC_wr_addr),
        .BC_wdata   (BC_wdata),
        .wen_bc     (wen_bc),
        .hit_count  (hit_count),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    // Synchronous read-first RAM model.
    always @(posedge CLK) begin
        BC_rdata <= mem[BC_rd_addr];
        if (wen_bc) mem[BC_wr_addr] <= BC_wdata;
    end

    task automatic drive(input int x, input int y, input logic h, input logic l);
        pix_if.pix_valid = 1'b1;
        pix_if.pix_x     = 8'(x);
        pix_if.pix_y     = 8'(y);
        pix_if.pix_hit   = h;
        pix_if.pix_last  = l;
    endtask

    task automatic idle_pix();
        pix_if.pix_valid = 1'b0;
        pix_if.pix_hit   = 1'b0;
        pix_if.pix_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        #1;
        tests_run++;
        if (BC_mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_mode: BC_mode=%0b want 1", BC_mode);
        end
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_accum();
        int n = 0;
        while (pix_if.pix_ready !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (pix_if.pix_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_accum: pix_ready=%0b after %0d cycles want 1", pix_if.pix_ready, n);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        start = 1'b0;
        pix_if.pix_x = '0;
        pix_if.pix_y = '0;
        idle_pix();
        for (int i = 0; i < 128; i++) mem[i] = 8'hA5;
        repeat (3) @(negedge CLK);
        tests_run++;
        if ({BC_mode, pix_if.pix_ready, wen_bc, done} !== 4'b1000 || hit_count !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: mode/ready/wen/done=%b hc=%0d want 1000 hc=0",
                     {BC_mode, pix_if.pix_ready, wen_bc, done}, hit_count);
        end
        tests_run++;
        if (BC_rd_addr !== 7'h0 || BC_wr_addr !== 7'h0 || BC_wdata !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: rd=%0h wr=%0h wd=%0h want 0 0 0",
                     BC_rd_addr, BC_wr_addr, BC_wdata);
        end
        RST = 1'b0;
        @(negedge CLK);
        tests_run++;
        if ({BC_mode, pix_if.pix_ready, wen_bc, done} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL idle_hold: mode/ready/wen/done=%b want 1000",
                     {BC_mode, pix_if.pix_ready, wen_bc, done});
        end
    endtask

    task automatic test_clear();
        int exp;
        int nz = 0;
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            exp = ((i / 8) << 4) | (i % 8);
            tests_run++;
            if (wen_bc !== 1'b1 || BC_wr_addr !== 7'(exp) || BC_wdata !== 8'h0 ||
                pix_if.pix_ready !== 1'b0 || BC_mode !== 1'b1) begin
                tests_failed++;
                $display("FAIL clear_%0d: wen=%0b addr=%0h wd=%0h rdy=%0b mode=%0b want 1 %0h 0 0 1",
                         i, wen_bc, BC_wr_addr, BC_wdata, pix_if.pix_ready, BC_mode, exp);
            end
            @(negedge CLK);
        end
        tests_run++;
        if (pix_if.pix_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accum_entry: pix_ready=%0b want 1", pix_if.pix_ready);
        end
        for (int i = 0; i < 128; i++) if ((i & 8) == 0 && mem[i] !== 8'h0) nz++;
        tests_run++;
        if (nz != 0) begin
            tests_failed++;
            $display("FAIL clear_mem: %0d nonzero fine boxes want 0", nz);
        end
    endtask

    task automatic test_single_hit();
        drive(37, 200, 1'b1, 1'b1);
        #1;
        tests_run++;
        if (BC_rd_addr !== 7'h16) begin
            tests_failed++;
            $display("FAIL single_rd: rd_addr=%0h want 16", BC_rd_addr);
        end
        @(negedge CLK);
        idle_pix();
        tests_run++;
        if (wen_bc !== 1'b1 || BC_wr_addr !== 7'h16 || BC_wdata !== 8'd1 ||
            pix_if.pix_ready !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_wr: wen=%0b addr=%0h wd=%0d rdy=%0b done=%0b want 1 16 1 0 0",
                     wen_bc, BC_wr_addr, BC_wdata, pix_if.pix_ready, done);
        end
        @(negedge CLK);
        tests_run++;
        if (done !== 1'b1 || BC_mode !== 1'b0 || hit_count !== 17'd1 || wen_bc !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: done=%0b mode=%0b hc=%0d wen=%0b want 1 0 1 0",
                     done, BC_mode, hit_count, wen_bc);
        end
        @(negedge CLK);
        tests_run++;
        if (done !== 1'b0 || BC_mode !== 1'b0 || hit_count !== 17'd1 || mem[7'h16] !== 8'd1) begin
            tests_failed++;
            $display("FAIL single_after: done=%0b mode=%0b hc=%0d mem16=%0d want 0 0 1 1",
                     done, BC_mode, hit_count, mem[7'h16]);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        wait_accum();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1'b1, (i == 2));
            @(negedge CLK);
            if (i == 2) idle_pix();
            tests_run++;
            if (wen_bc !== 1'b1 || BC_wr_addr !== 7'h00 || BC_wdata !== 8'(i + 1)) begin
                tests_failed++;
                $display("FAIL b2b_%0d: wen=%0b addr=%0h wd=%0d want 1 0 %0d",
                         i, wen_bc, BC_wr_addr, BC_wdata, i + 1);
            end
        end
        @(negedge CLK);
        tests_run++;
        if (done !== 1'b1 || hit_count !== 17'd3 || mem[0] !== 8'd3) begin
            tests_failed++;
            $display("FAIL b2b_final: done=%0b hc=%0d mem0=%0d want 1 3 3", done, hit_count, mem[0]);
        end
    endtask

    task automatic test_alternating();
        int   bx [5];
        int   ed [5];
        int   ea [5];
        int   hc [5];
        logic bh [5];
        bx = '{0, 9, 255, 100, 0};
        bh = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ea = '{'h00, 0, 'h77, 0, 'h00};
        ed = '{1, 0, 1, 0, 2};
        hc = '{1, 1, 2, 2, 3};
        pulse_start();
        wait_accum();
        for (int i = 0; i < 5; i++) begin
            drive(bx[i], bx[i], bh[i], (i == 4));
            @(negedge CLK);
            if (i == 4) idle_pix();
            tests_run++;
            if (wen_bc !== bh[i] || hit_count !== 17'(hc[i]) ||
                (bh[i] && (BC_wr_addr !== 7'(ea[i]) || BC_wdata !== 8'(ed[i])))) begin
                tests_failed++;
                $display("FAIL alt_%0d: wen=%0b addr=%0h wd=%0d hc=%0d want %0b %0h %0d %0d",
                         i, wen_bc, BC_wr_addr, BC_wdata, hit_count, bh[i], ea[i], ed[i], hc[i]);
            end
        end
        @(negedge CLK);
        tests_run++;
        if (done !== 1'b1 || mem[7'h00] !== 8'd2 || mem[7'h77] !== 8'd1) begin
            tests_failed++;
            $display("FAIL alt_final: done=%0b mem00=%0d mem77=%0d want 1 2 1",
                     done, mem[7'h00], mem[7'h77]);
        end
    endtask

    task automatic test_saturation();
        int exp;
        pulse_start();
        wait_accum();
        for (int i = 0; i < 300; i++) begin
            drive(70, 100, 1'b1, (i == 299));
            @(negedge CLK);
            if (i == 299) idle_pix();
            exp = (i + 1 > 255) ? 255 : i + 1;
            tests_run++;
            if (wen_bc !== 1'b1 || BC_wr_addr !== 7'h23 || BC_wdata !== 8'(exp)) begin
                tests_failed++;
                $display("FAIL sat_%0d: wen=%0b addr=%0h wd=%0d want 1 23 %0d",
                         i, wen_bc, BC_wr_addr, BC_wdata, exp);
            end
        end
        @(negedge CLK);
        tests_run++;
        if (done !== 1'b1 || hit_count !== 17'd300 || mem[7'h23] !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_final: done=%0b hc=%0d mem23=%0d want 1 300 255",
                     done, hit_count, mem[7'h23]);
        end
    endtask

    task automatic test_rst_mid_frame();
        int n = 0;
        pulse_start();
        wait_accum();
        drive(0, 0, 1'b1, 1'b0);
        @(negedge CLK);
        drive(255, 0, 1'b1, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        tests_run++;
        if (BC_mode !== 1'b1 || pix_if.pix_ready !== 1'b0 || wen_bc !== 1'b0 ||
            done !== 1'b0 || hit_count !== 17'd0) begin
            tests_failed++;
            $display("FAIL rst_mid: mode=%0b rdy=%0b wen=%0b done=%0b hc=%0d want 1 0 0 0 0",
                     BC_mode, pix_if.pix_ready, wen_bc, done, hit_count);
        end
        idle_pix();
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests_run++;
            if (BC_mode !== 1'b1 || pix_if.pix_ready !== 1'b0 || wen_bc !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_idle_%0d: mode=%0b rdy=%0b wen=%0b want 1 0 0",
                         i, BC_mode, pix_if.pix_ready, wen_bc);
            end
        end
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (wen_bc !== 1'b1 || BC_wr_addr !== 7'(i)) begin
                tests_failed++;
                $display("FAIL reclear_%0d: wen=%0b addr=%0h want 1 %0h", i, wen_bc, BC_wr_addr, i);
            end
            if (i < 3) @(negedge CLK);
            // A start while clearing must not restart the sweep.
            if (i == 1) start = 1'b1;
            if (i == 2) start = 1'b0;
        end
        while (pix_if.pix_ready !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        tests_run++;
        if (n != 61) begin
            tests_failed++;
            $display("FAIL reclear_len: %0d cycles to ACCUM from index 3 want 61", n);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_single_hit();
        test_back_to_back();
        test_alternating();
        test_saturation();
        test_rst_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bc_accum.md
Name: bc_accum

Overview:
- Box-count accumulation stage. It sits directly upstream of the square-grouping stage and fills the finest-level box-count memory bank from a pixel stream.
- It holds BC_mode high while it clears and accumulates. The square-grouping stage stays in reset for that whole time.
- It drops BC_mode when the finest-level counts are final. That hands the memory to the grouping stage, which builds the coarser levels.

Parameters:
- BOX_IDX, 3, bits per box coordinate; the finest grid is 2^BOX_IDX x 2^BOX_IDX boxes.
- PIX_BITS, 8, bits per pixel coordinate; box index = coordinate >> (PIX_BITS-BOX_IDX); PIX_BITS >= BOX_IDX.
- DATA_LEN, 8, box-count width; counts saturate.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame (honoured in IDLE/DONE only)
- pix_valid  in  1  pixel beat valid
- pix_ready  out  1  beat accepted when pix_valid&pix_ready
- pix_x  in  PIX_BITS  pixel column
- pix_y  in  PIX_BITS  pixel row
- pix_hit  in  1  pixel is set; only hits increment a box
- pix_last  in  1  final beat of frame
- BC_mode  out  1  high = box-counting owns memory; downstream held in reset
- BC_rd_addr  out  2*BOX_IDX+1  memory read address
- BC_rdata  in  DATA_LEN  memory read data, 1-cycle synchronous latency, read-first on same-address write
- BC_wr_addr  out  2*BOX_IDX+1  memory write address
- BC_wdata  out  DATA_LEN  write data
- wen_bc  out  1  write enable
- hit_count  out  2*PIX_BITS+1  hits accepted in current frame (normalisation for later stages)
- done  out  1  one-cycle pulse when counts are final

Behaviour:
- Address format, both read and write: {box_x[BOX_IDX-1:0], 1'b0, box_y[BOX_IDX-1:0]}. The bank bit is always 0 for this block; bank 1 belongs to the grouping stage.
- Reset values: state IDLE, BC_mode=1, pix_ready=0, wen_bc=0, done=0, hit_count=0, all addresses and wdata 0.
- State machine: IDLE -> CLEAR -> ACCUM -> DRAIN -> DONE.
- IDLE: BC_mode=1. start -> CLEAR; hit_count<=0.
- CLEAR:
  - Writes 0 to all 2^(2*BOX_IDX) finest boxes, one per cycle. Order: box_y is the inner counter, box_x the outer.
  - wen_bc=1 each cycle; pix_ready=0.
  - After the last box (all-ones x and y) -> ACCUM.
- ACCUM: pix_ready=1. Two-stage pipeline.
  - S0: on an accepted beat with pix_hit=1, drive BC_rd_addr from the box index and register the address into S1 (s1_valid<=1). Beats with pix_hit=0 are accepted and ignored.
  - S1, one cycle later: wen_bc=1, BC_wr_addr=S1 address, BC_wdata=min(src+1, 2^DATA_LEN-1).
  - src selection: src is the previous cycle's BC_wdata when the previous cycle wrote the same address (forwarding, needed because of read-first RAM). Otherwise src=BC_rdata.
  - Back-to-back hits on one box therefore count correctly at full rate.
  - hit_count increments on every accepted hit and saturates at all-ones.
  - An accepted beat with pix_last=1 -> DRAIN; pix_ready falls the next cycle.
- DRAIN: completes any pending S1 write; pix_ready=0. -> DONE next cycle.
- DONE:
  - On entry: done=1 for one cycle; BC_mode=0 from that cycle onward.
  - Memory contents and hit_count stay stable.
  - start -> CLEAR, with BC_mode=1 in the same cycle start is sampled; hit_count<=0.
- start outside IDLE/DONE is ignored.
- pix_valid outside ACCUM is not accepted (pix_ready=0).
- Saturation: a box at 2^DATA_LEN-1 stays there, and the write is still issued.
- RST mid-frame: returns to IDLE immediately with BC_mode=1. Partial memory contents are don't-care; the next start re-clears.
- Throughput: 1 beat/cycle in ACCUM. Frame latency = 2^(2*BOX_IDX) clear cycles + beats + 2.

Decomposition:
- Shared package holds:
  - state enum {IDLE, CLEAR, ACCUM, DRAIN, DONE};
  - addr_t width 2*BOX_IDX+1;
  - BANK_FINE=0, BANK_COARSE=1;
  - an address-pack function {x, bank, y}, reused by the grouping stage.
- One sub-module: bc_rmw_pipe. It holds the S1 register, forwarding compare and saturating increment. The FSM, clear counter and hit counter stay in bc_accum.

Test Plan (all at defaults: BOX_IDX=3, PIX_BITS=8, DATA_LEN=8):
- Reset then start -> BC_mode stays 1; 64 CLEAR writes of 0; write addresses 0x00,0x01..0x06,0x07, then 0x10..0x17, ..., last 0x77; pix_ready=0 throughout; ACCUM begins on cycle 65.
- Single hit (37,200), pix_last=1 -> read then write at addr 0x16 (x=1, y=6) with wdata=1; done pulses 2 cycles after the beat; hit_count=1; BC_mode falls.
- Three consecutive hits at (0,0) on back-to-back cycles -> writes to 0x00 of 1, 2, 3; forwarding exercised; final memory value 3.
- Alternating hits (0,0),(255,255),(0,0) -> 0x00 gets 1 then 2; 0x77 gets 1; beats with pix_hit=0 interleaved produce no writes and leave hit_count unchanged.
- 300 hits to box (2,3) -> stored value 255 (saturated); hit_count=300.
- RST asserted mid-ACCUM -> next cycle BC_mode=1, pix_ready=0, wen_bc=0, state IDLE; a new start re-runs CLEAR; a second start while in CLEAR is ignored.
